// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit width, header field positions, injector FSM
// encodings and the header-flit builder.
// Imported by the network-interface injector and its interface.
package noc_pkg;

  localparam int FLIT_W  = 8;
  localparam int COORD_W = 3;
  localparam int LEN_W   = 2;
  localparam int DATA_W  = 32;

  // Header flit layout: {dst_x, dst_y, len}
  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_MSB = 1;
  localparam int HDR_Y_LSB   = 2;
  localparam int HDR_Y_MSB   = 4;
  localparam int HDR_X_LSB   = 5;
  localparam int HDR_X_MSB   = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HEAD = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;

  // Message latched from the PE for the duration of one packet
  typedef struct packed {
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
    logic [LEN_W-1:0]   len;
    logic [DATA_W-1:0]  data;
  } msg_t;

  function automatic logic [FLIT_W-1:0] build_header(input logic [COORD_W-1:0] x,
                                                     input logic [COORD_W-1:0] y,
                                                     input logic [LEN_W-1:0]   len);
    logic [FLIT_W-1:0] h;
    h = '0;
    h[HDR_X_MSB:HDR_X_LSB]     = x;
    h[HDR_Y_MSB:HDR_Y_LSB]     = y;
    h[HDR_LEN_MSB:HDR_LEN_LSB] = len;
    return h;
  endfunction

endpackage

// File: rtl/ni_flit_injector_if.sv
// PE-message handshake plus local-FIFO write/credit signals of the injector.
// Ports: pe_* message handshake, fifo_write/fifo_data flit strobe, credit_in return,
// credits/busy/credit_err status. slave = injector view, master = PE/router view.
interface ni_flit_injector_if #(parameter int CRED_W = 4);
  import noc_pkg::*;

  logic                  pe_valid;
  logic                  pe_ready;
  logic [COORD_W-1:0]    pe_dst_x;
  logic [COORD_W-1:0]    pe_dst_y;
  logic [LEN_W-1:0]      pe_len;
  logic [DATA_W-1:0]     pe_data;
  logic                  fifo_write;
  logic [FLIT_W-1:0]     fifo_data;
  logic                  credit_in;
  logic [CRED_W-1:0]     credits;
  logic                  busy;
  logic                  credit_err;

  modport slave (
    input  pe_valid, pe_dst_x, pe_dst_y, pe_len, pe_data, credit_in,
    output pe_ready, fifo_write, fifo_data, credits, busy, credit_err
  );

  modport master (
    output pe_valid, pe_dst_x, pe_dst_y, pe_len, pe_data, credit_in,
    input  pe_ready, fifo_write, fifo_data, credits, busy, credit_err
  );

endinterface

// File: rtl/ni_credit_counter.sv
// Credit counter mirroring free downstream FIFO slots; resets to DEPTH.
// Ports: inc_i (slot freed), dec_i (flit issued), count_o, err_o (sticky overflow).
// Simultaneous inc/dec cancel; inc at DEPTH saturates and raises err_o.
module ni_credit_counter #(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         err_o
);

  localparam logic [W-1:0] MAX = W'(DEPTH);

  logic [W-1:0] count_q, count_d;
  logic         err_q, err_d;

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (inc_i && !dec_i) begin
      if (count_q == MAX) err_d = 1'b1;
      else                count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= MAX;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_o = count_q;
  assign err_o   = err_q;

endmodule

// File: rtl/ni_flit_injector.sv
// Packetizes one PE message into header + 1..4 payload flits for the router local FIFO.
// Ports: clk, rst (async active-high), bus (slave modport: PE handshake, FIFO write, credits).
// Header issues the edge after acceptance; one flit per cycle while credits > 0, else stall.
module ni_flit_injector
  import noc_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CRED_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  ni_flit_injector_if.slave     bus
);

  logic [1:0]        state_q, state_d;
  msg_t              msg_q, msg_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              fifo_write_q, fifo_write_d;
  logic [FLIT_W-1:0] fifo_data_q, fifo_data_d;

  logic [CRED_W-1:0] credits;
  logic              credit_err;
  logic              issue;

  // A flit may only leave when a credit was available before the edge
  assign issue = ((state_q == ST_HEAD) || (state_q == ST_PAY)) && (credits != '0);

  ni_credit_counter #(.DEPTH(FIFO_DEPTH), .W(CRED_W)) u_credits (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (bus.credit_in),
    .dec_i   (issue),
    .count_o (credits),
    .err_o   (credit_err)
  );

  always_comb begin
    state_d      = state_q;
    msg_d        = msg_q;
    idx_d        = idx_q;
    fifo_write_d = issue;
    fifo_data_d  = fifo_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.pe_valid) begin
          msg_d.dst_x = bus.pe_dst_x;
          msg_d.dst_y = bus.pe_dst_y;
          msg_d.len   = bus.pe_len;
          msg_d.data  = bus.pe_data;
          state_d     = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (issue) begin
          fifo_data_d = build_header(msg_q.dst_x, msg_q.dst_y, msg_q.len);
          idx_d       = '0;
          state_d     = ST_PAY;
        end
      end
      ST_PAY: begin
        if (issue) begin
          fifo_data_d = msg_q.data[{idx_q, 3'b000} +: FLIT_W];
          if (idx_q == msg_q.len) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      msg_q        <= '0;
      idx_q        <= '0;
      fifo_write_q <= 1'b0;
      fifo_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      msg_q        <= msg_d;
      idx_q        <= idx_d;
      fifo_write_q <= fifo_write_d;
      fifo_data_q  <= fifo_data_d;
    end
  end

  assign bus.pe_ready   = (state_q == ST_IDLE);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.fifo_write = fifo_write_q;
  assign bus.fifo_data  = fifo_data_q;
  assign bus.credits    = credits;
  assign bus.credit_err = credit_err;

endmodule

// File: tb/tb_ni_flit_injector.sv
// Self-checking bench for ni_flit_injector: scoreboard of expected flits,
// credit stall/resume, coincident credit return, reset mid-packet, credit overflow.
// Flits are compared on the falling edge as they appear on the FIFO write port.
module tb_ni_flit_injector;

  logic clk;
  logic rst;
  int   cyc;
  int   n_pass;
  int   n_chk;

  logic [7:0] exp_q[$];
  int         wr_cyc[$];

  ni_flit_injector_if #(.CRED_W(4)) bus ();

  ni_flit_injector #(.FIFO_DEPTH(8), .CRED_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Flit monitor / scoreboard consumer
  always @(negedge clk) begin
    if (!rst && bus.fifo_write) begin
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_flit", {24'h0, bus.fifo_data}, 32'hFFFF_FFFF);
      else check("flit", {24'h0, bus.fifo_data}, {24'h0, exp_q.pop_front()});
    end
  end

  int acc_cyc;

  task automatic send(input logic [2:0] x, input logic [2:0] y, input logic [1:0] len,
                      input logic [31:0] data);
    int t;
    logic [7:0] hdr;
    t = 0;
    @(negedge clk);
    while (!bus.pe_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      check("send_timeout", 32'd0, 32'd1);
      return;
    end
    bus.pe_dst_x = x;
    bus.pe_dst_y = y;
    bus.pe_len   = len;
    bus.pe_data  = data;
    bus.pe_valid = 1'b1;
    hdr = {x, y, len};
    exp_q.push_back(hdr);
    for (int i = 0; i <= int'(len); i++) exp_q.push_back(data[8*i +: 8]);
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    bus.pe_valid = 1'b0;
    bus.pe_data  = 32'hDEAD_BEEF;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (bus.busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("idle_timeout", 32'd1, 32'd0);
    #1;
  endtask

  task automatic give_credit(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.credit_in = 1'b1;
      @(negedge clk);
      bus.credit_in = 1'b0;
    end
  endtask

  initial begin
    n_pass = 0;
    n_chk  = 0;
    cyc    = 0;
    rst    = 1'b1;
    bus.pe_valid  = 1'b0;
    bus.pe_dst_x  = '0;
    bus.pe_dst_y  = '0;
    bus.pe_len    = '0;
    bus.pe_data   = '0;
    bus.credit_in = 1'b0;

    // 1: reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_credits", 32'(bus.credits), 32'd8);
    check("rst_pe_ready", 32'(bus.pe_ready), 32'd1);
    check("rst_fifo_write", 32'(bus.fifo_write), 32'd0);
    check("rst_fifo_data", 32'(bus.fifo_data), 32'h00);
    check("rst_credit_err", 32'(bus.credit_err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;

    // 2: single-byte packet, latency and credit use
    wr_cyc.delete();
    send(3'd2, 3'd5, 2'd0, 32'h0000_00A5);
    wait_idle();
    check("t2_nflits", 32'(wr_cyc.size()), 32'd2);
    if (wr_cyc.size() == 2) begin
      check("t2_hdr_latency", 32'(wr_cyc[0] - acc_cyc), 32'd1);
      check("t2_pay_consec", 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);
    end
    check("t2_credits", 32'(bus.credits), 32'd6);
    @(negedge clk);
    check("t2_pe_ready_after", 32'(bus.pe_ready), 32'd1);
    check("t2_write_low_after", 32'(bus.fifo_write), 32'd0);
    give_credit(2);
    @(negedge clk);
    check("t2_credits_back", 32'(bus.credits), 32'd8);

    // 3: four-byte packet back-to-back
    wr_cyc.delete();
    send(3'd7, 3'd0, 2'd3, 32'h1122_3344);
    wait_idle();
    check("t3_nflits", 32'(wr_cyc.size()), 32'd5);
    if (wr_cyc.size() == 5) check("t3_span", 32'(wr_cyc[4] - wr_cyc[0]), 32'd4);
    check("t3_credits", 32'(bus.credits), 32'd3);
    give_credit(5);
    @(negedge clk);
    check("t3_credits_back", 32'(bus.credits), 32'd8);

    // 4: credit exhaustion stall and single-credit resume
    wr_cyc.delete();
    send(3'd1, 3'd3, 2'd3, 32'hA1B2_C3D4);
    send(3'd4, 3'd6, 2'd3, 32'h5566_7788);
    repeat (20) @(negedge clk);
    #1;
    check("t4_nflits_stall", 32'(wr_cyc.size()), 32'd8);
    check("t4_credits_zero", 32'(bus.credits), 32'd0);
    check("t4_write_low", 32'(bus.fifo_write), 32'd0);
    check("t4_busy", 32'(bus.busy), 32'd1);
    give_credit(1);
    repeat (5) @(negedge clk);
    #1;
    check("t4_one_more", 32'(wr_cyc.size()), 32'd9);
    check("t4_credits_zero2", 32'(bus.credits), 32'd0);
    give_credit(1);
    wait_idle();
    check("t4_nflits_all", 32'(wr_cyc.size()), 32'd10);
    give_credit(8);
    @(negedge clk);
    check("t4_credits_back", 32'(bus.credits), 32'd8);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t4_no_err", 32'(bus.credit_err), 32'd0);

    // 5: credit returned on every issue edge, then reset mid-packet
    wr_cyc.delete();
    send(3'd7, 3'd0, 2'd3, 32'h1122_3344);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      check("t5_credits_hold", 32'(bus.credits), 32'd8);
      if (wr_cyc.size() >= 2) begin
        bus.credit_in = 1'b0;
        rst = 1'b1;
        break;
      end
      bus.credit_in = bus.busy && (bus.credits != 4'd0);
    end
    bus.credit_in = 1'b0;
    check("t5_two_before_rst", 32'(wr_cyc.size()), 32'd2);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    wr_cyc.delete();
    repeat (10) @(negedge clk);
    #1;
    check("t5_no_writes", 32'(wr_cyc.size()), 32'd0);
    check("t5_idle", 32'(bus.busy), 32'd0);
    check("t5_pe_ready", 32'(bus.pe_ready), 32'd1);
    check("t5_credits", 32'(bus.credits), 32'd8);

    // 6: credit overflow is sticky until reset
    give_credit(1);
    @(negedge clk);
    check("t6_err_set", 32'(bus.credit_err), 32'd1);
    check("t6_credits_sat", 32'(bus.credits), 32'd8);
    repeat (3) @(negedge clk);
    check("t6_err_sticky", 32'(bus.credit_err), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_err_cleared", 32'(bus.credit_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
